// File: rtl/riscv_mem_arb_pkg.sv
// riscv_mem_arb_pkg: shared types for the unified-memory arbiter.
// FSM state encoding, owner ids and the wait-counter width.
package riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// mem_arb_wait_counter: loadable down-counter for the memory latency.
// last_o is high while the count is 1, i.e. in the final wait cycle.
module mem_arb_wait_counter
    import riscv_mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: load has priority, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: serialises core and debug accesses to one memory.
// Define MEM_ARB_RR_EN for round-robin ties; default is debug priority.
module riscv_mem_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("MEM_LAT must be in the range 1..15");
    end

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              win;
    logic              any_req;
    logic              last;

    assign any_req = c_req | d_req;

    mem_arb_wait_counter u_wait (
        .clk    (clk),
        .reset  (reset),
        .load_i (state_q == ISSUE),
        .val_i  (CNT_W'(MEM_LAT)),
        .dec_i  (state_q == WAIT),
        .last_o (last)
    );

    // pick the requester granted in the next IDLE decision
    always_comb begin
`ifdef MEM_ARB_RR_EN
        if (c_req && d_req) begin
            win = ~owner_q;
        end else begin
            win = d_req ? OWN_DBG : OWN_CORE;
        end
`else
        win = d_req ? OWN_DBG : OWN_CORE;
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // latch the winning request and capture read data on the last wait
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q   <= OWN_CORE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                owner_q <= win;
                we_q    <= win ? d_we : c_we;
                addr_q  <= win ? d_addr : c_addr;
                wdata_q <= win ? d_wdata : c_wdata;
            end
            if (state_q == WAIT && last && !we_q) begin
                if (owner_q == OWN_DBG) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    c_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // memory strobe in ISSUE, owner ack in DONE, bus quiet otherwise
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        c_ack     = 1'b0;
        d_ack     = 1'b0;
        unique case (state_q)
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            DONE: begin
                c_ack = (owner_q == OWN_CORE);
                d_ack = (owner_q == OWN_DBG);
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign owner   = owner_q;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: scoreboard bench for the memory arbiter.
// Transaction-level model predicts grants, strobes, acks and read data.
module tb_riscv_mem_arbiter;

    localparam int L = 2;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        p;
        logic [31:0] rd;
    } ack_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rq;
    logic [1:0]  rwe;
    logic [31:0] raddr [2];
    logic [31:0] rwd   [2];

    logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
    logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, busy, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    assign c_req   = rq[0];
    assign c_we    = rwe[0];
    assign c_addr  = raddr[0];
    assign c_wdata = rwd[0];
    assign d_req   = rq[1];
    assign d_we    = rwe[1];
    assign d_addr  = raddr[1];
    assign d_wdata = rwd[1];

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_ack     (c_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          free_cyc = 0;
    int          busy_from = 0;
    int          busy_to = -1;
    int          rst_chk = -1;
    int          last_grant = -100;
    logic        own_exp = 1'b0;
    logic [31:0] last_rd [2];
    logic        gr [2];
    mem_exp_t    sbm [$];
    ack_exp_t    sba [$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] phys    [logic [31:0]];

    function automatic logic [31:0] dflt(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rd_ref(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rd_phys(logic [31:0] a);
        return phys.exists(a) ? phys[a] : dflt(a);
    endfunction

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void bad(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s cyc=%0d got=event exp=none", nm, cyc);
    endfunction

    // memory macro: writes land at once, reads appear L cycles after mem_en
    int          cd = -1;
    logic [31:0] pend = '0;
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) phys[mem_addr] = mem_wdata;
            else pend = rd_phys(mem_addr);
            cd = L;
        end else if (cd >= 0) begin
            cd--;
        end
        mem_rdata = (cd == 0) ? pend : $urandom;
    end

    // reference model: evaluated once per cycle with that cycle's inputs
    task automatic model_eval();
        int          pi;
        logic [31:0] e;
        mem_exp_t    m;
        ack_exp_t    a;
        if (!reset) begin
            sbm.delete();
            sba.delete();
            free_cyc   = cyc + 1;
            busy_to    = -1;
            own_exp    = 1'b0;
            last_rd[0] = '0;
            last_rd[1] = '0;
            gr[0]      = 1'b0;
            gr[1]      = 1'b0;
            rst_chk    = cyc + 1;
        end else if (cyc >= free_cyc && rq != 2'b00) begin
`ifdef MEM_ARB_RR_EN
            if (rq == 2'b11) pi = own_exp ? 0 : 1;
            else pi = rq[1] ? 1 : 0;
`else
            pi = rq[1] ? 1 : 0;
`endif
            if (rwe[pi]) begin
                e = last_rd[pi];
                ref_mem[raddr[pi]] = rwd[pi];
            end else begin
                e = rd_ref(raddr[pi]);
                last_rd[pi] = e;
            end
            m.cyc = cyc + 1;
            m.we = rwe[pi];
            m.addr = raddr[pi];
            m.wd = rwd[pi];
            sbm.push_back(m);
            a.cyc = cyc + 2 + L;
            a.p = pi[0];
            a.rd = e;
            sba.push_back(a);
            busy_from  = cyc + 1;
            busy_to    = cyc + 2 + L;
            free_cyc   = cyc + 3 + L;
            own_exp    = pi[0];
            gr[pi]     = 1'b1;
            last_grant = cyc;
        end
    endtask

    // monitor: pops expectations whenever the DUT strobes or acks
    always @(posedge clk) begin
        mem_exp_t m;
        ack_exp_t a;
        cyc++;
        #1;
        while (sbm.size() > 0 && sbm[0].cyc < cyc) begin
            bad("mem_en_missing");
            void'(sbm.pop_front());
        end
        if (mem_en) begin
            if (sbm.size() == 0 || sbm[0].cyc != cyc) begin
                bad("mem_en_unexpected");
            end else begin
                m = sbm.pop_front();
                chk("mem_we", 32'(mem_we), 32'(m.we));
                chk("mem_addr", mem_addr, m.addr);
                chk("mem_wdata", mem_wdata, m.wd);
            end
        end else begin
            chk("mem_idle", mem_addr | mem_wdata | 32'(mem_we), 32'd0);
        end
        while (sba.size() > 0 && sba[0].cyc < cyc) begin
            bad("ack_missing");
            void'(sba.pop_front());
        end
        if (c_ack && d_ack) begin
            bad("double_ack");
        end else if (c_ack || d_ack) begin
            if (sba.size() == 0 || sba[0].cyc != cyc) begin
                bad("ack_unexpected");
            end else begin
                a = sba.pop_front();
                chk("ack_port", 32'(d_ack), 32'(a.p));
                chk("ack_rdata", d_ack ? d_rdata : c_rdata, a.rd);
            end
        end
        chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
        chk("owner", 32'(owner), 32'(own_exp));
        if (cyc == rst_chk) begin
            chk("rst_c_rdata", c_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
        end
    end

    task automatic step();
        model_eval();
        @(negedge clk);
    endtask

    task automatic set_req(int p, logic we, logic [31:0] a, logic [31:0] d);
        rq[p]    = 1'b1;
        rwe[p]   = we;
        raddr[p] = a;
        rwd[p]   = d;
    endtask

    task automatic set_rand(int p);
        logic [31:0] a;
        a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic wait_ack(int p, int lim);
        int n = 0;
        while (!(p == 1 ? d_ack : c_ack) && n < lim) begin
            step();
            n++;
        end
        if (n >= lim) bad("ack_timeout");
        gr[p] = 1'b0;
    endtask

    task automatic drain(int lim);
        int n = 0;
        while (rq != 2'b00 && n < lim) begin
            if (c_ack) rq[0] = 1'b0;
            if (d_ack) rq[1] = 1'b0;
            if (rq != 2'b00) step();
            n++;
        end
        if (n >= lim) bad("drain_timeout");
        gr[0] = 1'b0;
        gr[1] = 1'b0;
    endtask

    task automatic drive(int p);
        logic ack;
        ack = (p == 1) ? d_ack : c_ack;
        if (ack) begin
            gr[p] = 1'b0;
            if (rq[p] && $urandom_range(0, 1) == 1) set_rand(p);
            else rq[p] = 1'b0;
        end else if (!rq[p] && !gr[p]) begin
            if ($urandom_range(0, 3) == 0) set_rand(p);
        end else if (rq[p] && gr[p] && $urandom_range(0, 7) == 0) begin
            rq[p] = 1'b0;
        end
    endtask

    initial begin
        int g0;
        int n;
        reset = 1'b0;
        rq = 2'b00;
        rwe = 2'b00;
        for (int i = 0; i < 2; i++) begin
            raddr[i] = '0;
            rwd[i] = '0;
            last_rd[i] = '0;
            gr[i] = 1'b0;
        end
        ref_mem[32'h100] = 32'hDEADBEEF;
        phys[32'h100] = 32'hDEADBEEF;
        @(negedge clk);

        // reset held while the core requests
        set_req(0, 1'b0, 32'h100, 32'h0);
        repeat (3) step();
        reset = 1'b1;

        // core read of 0x100
        wait_ack(0, 20);
        rq[0] = 1'b0;
        step();

        // debug write
        set_req(1, 1'b1, 32'h4, 32'h12345678);
        wait_ack(1, 20);
        rq[1] = 1'b0;
        step();

        // simultaneous requests
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b0, 32'h4, 32'h0);
        step();
        drain(40);
        step();

        // back-to-back core reads
        set_req(0, 1'b0, 32'h104, 32'h0);
        wait_ack(0, 20);
        set_req(0, 1'b0, 32'h4, 32'h0);
        step();
        wait_ack(0, 20);
        rq[0] = 1'b0;
        step();

        // reset in the first wait cycle
        g0 = last_grant;
        set_req(0, 1'b0, 32'h108, 32'h0);
        n = 0;
        while ((last_grant == g0 || cyc != last_grant + 2) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) bad("wait_reach_timeout");
        reset = 1'b0;
        rq[0] = 1'b0;
        step();
        reset = 1'b1;
        repeat (L + 5) step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(0);
            drive(1);
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            step();
        end

        reset = 1'b1;
        rq = 2'b00;
        repeat (L + 6) step();
        chk("drain_mem_q", 32'(sbm.size()), 32'd0);
        chk("drain_ack_q", 32'(sba.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
